// File: rtl/seg7_scan_driver.sv
// Scan driver for a 4-digit common-anode 7-segment display.
// Performs hex decode, dead-time blanking, leading-zero blanking and frame-synchronous shadow updates.
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned DEAD_CYCLES = 16,
    parameter bit          LZB         = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_we_i,
    input  logic [15:0] disp_data_i,
    input  logic [3:0]  disp_dp_i,
    input  logic        disp_en_i,
    input  logic        raw_mode_i,
    input  logic [11:0] raw_digital_i,
    output logic [3:0]  an_o,
    output logic [7:0]  seg_o,
    output logic        frame_o
);

    localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [19:0]      shadow_q, shadow_d;
    logic [19:0]      pending_q, pending_d;
    logic             pend_q, pend_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_q, frame_d;

    logic             cnt_wrap;
    logic             boundary;
    logic [3:0]       nib;
    logic [3:0]       dp_bits;
    logic [15:0]      upper;
    logic             blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h40;
            4'h1: hex_decode = 7'h79;
            4'h2: hex_decode = 7'h24;
            4'h3: hex_decode = 7'h30;
            4'h4: hex_decode = 7'h19;
            4'h5: hex_decode = 7'h12;
            4'h6: hex_decode = 7'h02;
            4'h7: hex_decode = 7'h78;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h10;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h03;
            4'hC: hex_decode = 7'h46;
            4'hD: hex_decode = 7'h21;
            4'hE: hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        boundary = cnt_wrap && (idx_q == 2'd3);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;

        pending_d = pending_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        if (disp_we_i) begin
            pending_d = {disp_dp_i, disp_data_i};
            pend_d    = 1'b1;
        end
        // A write landing on the boundary itself bypasses pending so it shows next frame.
        if (boundary) begin
            if (disp_we_i) begin
                shadow_d = {disp_dp_i, disp_data_i};
            end else if (pend_q) begin
                shadow_d = pending_q;
            end
            pend_d = 1'b0;
        end
        frame_d = boundary;

        nib     = shadow_q[{idx_q, 2'b00} +: 4];
        dp_bits = shadow_q[19:16];
        upper   = shadow_q[15:0] >> {idx_q, 2'b00};
        blank   = LZB && (idx_q != 2'd0) && (upper == '0);

        if (raw_mode_i) begin
            an_d  = raw_digital_i[11:8];
            seg_d = raw_digital_i[7:0];
        end else if (!disp_en_i || (cnt_q < DEAD_END) || blank) begin
            an_d  = '1;
            seg_d = '1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = {~dp_bits[idx_q], hex_decode(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            an_q      <= '1;
            seg_q     <= '1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random traffic
// compared against a cycle-indexed arithmetic model of the display.
module tb_seg7_scan_driver;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned DEAD    = 2;
    localparam int unsigned FRAME   = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_we = 1'b0;
    logic [15:0] disp_data = '0;
    logic [3:0]  disp_dp = '0;
    logic        disp_en = 1'b1;
    logic        raw_mode = 1'b0;
    logic [11:0] raw_digital = '0;
    logic [3:0]  an_o;
    logic [7:0]  seg_o;
    logic        frame_o;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .CLK_DIV    (CLK_DIV),
        .DEAD_CYCLES(DEAD),
        .LZB        (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_we_i    (disp_we),
        .disp_data_i  (disp_data),
        .disp_dp_i    (disp_dp),
        .disp_en_i    (disp_en),
        .raw_mode_i   (raw_mode),
        .raw_digital_i(raw_digital),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .frame_o      (frame_o)
    );

    int checks   = 0;
    int failures = 0;

    // Model: m_t counts cycles since reset release; slot position follows by division.
    int          m_t = 0;
    logic [19:0] m_shown = '0;
    logic [19:0] m_pval = '0;
    logic        m_pend = 1'b0;
    int          last_idx = 0;
    int          last_cnt = 0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int          cnt;
        int          idx;
        int          val;
        int          nib;
        logic [3:0]  e_an;
        logic [7:0]  e_seg;
        logic        e_fr;
        cnt  = m_t % CLK_DIV;
        idx  = (m_t / CLK_DIV) % 4;
        e_fr = (m_t % FRAME) == (FRAME - 1);
        val  = int'(m_shown[15:0]);
        if (raw_mode) begin
            e_an  = raw_digital[11:8];
            e_seg = raw_digital[7:0];
        end else if (!disp_en || cnt < DEAD || (idx > 0 && val < (1 << (4 * idx)))) begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
        end else begin
            nib   = (val >> (4 * idx)) % 16;
            e_an  = 4'(15 - (1 << idx));
            e_seg = {~m_shown[16 + idx], dec_tab[nib]};
        end
        if (e_fr) begin
            if (disp_we) m_shown = {disp_dp, disp_data};
            else if (m_pend) m_shown = m_pval;
            m_pend = 1'b0;
        end else if (disp_we) begin
            m_pval = {disp_dp, disp_data};
            m_pend = 1'b1;
        end
        last_idx = idx;
        last_cnt = cnt;
        m_t++;
        @(posedge clk);
        #1;
        check("an",    {4'h0, an_o},    {4'h0, e_an});
        check("seg",   seg_o,           e_seg);
        check("frame", {7'h0, frame_o}, {7'h0, e_fr});
        disp_we = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        disp_we = 1'b0;
        @(posedge clk);
        #1;
        check("rst_an",    {4'h0, an_o},    8'h0F);
        check("rst_seg",   seg_o,           8'hFF);
        check("rst_frame", {7'h0, frame_o}, 8'h00);
        rst     = 1'b0;
        m_t     = 0;
        m_shown = '0;
        m_pval  = '0;
        m_pend  = 1'b0;
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] dp);
        disp_we   = 1'b1;
        disp_data = d;
        disp_dp   = dp;
        tick();
    endtask

    task automatic goto_slot(input int idx, input int cnt);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(last_idx == idx && last_cnt == cnt) && n < 64);
    endtask

    task automatic lit(input string tag, input logic [3:0] an, input logic [7:0] seg);
        check({tag, "_an"},  {4'h0, an_o}, {4'h0, an});
        check({tag, "_seg"}, seg_o,        seg);
    endtask

    initial begin
        logic [15:0] r;
        @(posedge clk);
        #1;
        do_reset();

        // 1: first frame after reset shows the 0x1234 write in the following frame
        write(16'h1234, 4'h0);
        goto_slot(3, 7);
        check("frame_at_32", {7'h0, frame_o}, 8'h01);
        goto_slot(0, 2); lit("t1_d0", 4'hE, 8'h99);
        goto_slot(1, 2); lit("t1_d1", 4'hD, 8'hB0);
        goto_slot(2, 2); lit("t1_d2", 4'hB, 8'hA4);
        goto_slot(3, 2); lit("t1_d3", 4'h7, 8'hF9);
        goto_slot(0, 1); lit("t1_dead", 4'hF, 8'hFF);

        // 2: leading-zero blanking
        write(16'h0005, 4'h0);
        goto_slot(3, 7);
        goto_slot(0, 2); lit("t2_5_d0", 4'hE, 8'h92);
        goto_slot(1, 2); lit("t2_5_d1", 4'hF, 8'hFF);
        write(16'h0000, 4'h0);
        goto_slot(3, 7);
        goto_slot(0, 2); lit("t2_0_d0", 4'hE, 8'hC0);
        write(16'h0800, 4'h0);
        goto_slot(3, 7);
        goto_slot(0, 2); lit("t2_8_d0", 4'hE, 8'hC0);
        goto_slot(1, 2); lit("t2_8_d1", 4'hD, 8'hC0);
        goto_slot(2, 2); lit("t2_8_d2", 4'hB, 8'h80);
        goto_slot(3, 2); lit("t2_8_d3", 4'hF, 8'hFF);

        // 3: tear-free update and boundary bypass
        write(16'h1234, 4'h0);
        goto_slot(3, 7);
        goto_slot(1, 2); lit("t3_d1", 4'hD, 8'hB0);
        write(16'hAAAA, 4'h0);
        goto_slot(2, 2); lit("t3_d2", 4'hB, 8'hA4);
        goto_slot(3, 2); lit("t3_d3", 4'h7, 8'hF9);
        goto_slot(0, 2); lit("t3_next", 4'hE, 8'h88);
        goto_slot(3, 6);
        write(16'h1234, 4'h0);
        goto_slot(0, 2); lit("t3_bypass", 4'hE, 8'h99);

        // 4: decimal point and display disable
        write(16'h0008, 4'b0001);
        goto_slot(3, 7);
        goto_slot(0, 2); lit("t4_dp", 4'hE, 8'h00);
        disp_en = 1'b0;
        goto_slot(0, 2); lit("t4_off", 4'hF, 8'hFF);
        goto_slot(3, 7);
        check("t4_frame", {7'h0, frame_o}, 8'h01);
        disp_en = 1'b1;

        // 5: raw passthrough has priority
        disp_en     = 1'b0;
        raw_mode    = 1'b1;
        raw_digital = 12'h7A4;
        tick(); lit("t5_raw", 4'h7, 8'hA4);
        disp_en  = 1'b1;
        raw_mode = 1'b0;
        tick();
        tick();

        // 6: reset discards a pending write
        goto_slot(1, 3);
        write(16'h5555, 4'hF);
        do_reset();
        goto_slot(0, 2); lit("t6_d0", 4'hE, 8'hC0);
        goto_slot(1, 2); lit("t6_d1", 4'hF, 8'hFF);
        goto_slot(3, 7);
        goto_slot(0, 2); lit("t6_after", 4'hE, 8'hC0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: r = r & 16'h000F;
                    1: r = r & 16'h00FF;
                    2: r = r & 16'h0FFF;
                    default: r = r;
                endcase
                disp_we   = 1'b1;
                disp_data = r;
                disp_dp   = 4'($urandom);
            end
            disp_en     = ($urandom_range(0, 9) != 0);
            raw_mode    = ($urandom_range(0, 19) == 0);
            raw_digital = 12'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
